// File: rtl/yif_queue.sv
`default_nettype none
// ============================================================================
// Module   : yif_queue
// Purpose  : First-word fall-through instruction queue between fetch and
//            decode. Flushes on redirect and presents a NOP when empty.
// Revision : 1.0 - initial release
// ============================================================================
module yif_queue #(
    parameter int unsigned      DEPTH = 4,
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_ins,
    input  logic [WIDTH-1:0]           in_pcp4,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_ins,
    output logic [WIDTH-1:0]           out_pcp4,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [7:0]         drop_q, drop_d;
    logic               w_push;
    logic               w_pop;
    logic               w_full;

    // Ready and valid come from occupancy only, so no combinational
    // path exists from out_ready to in_ready.
    assign w_full    = (count_q == CW'(DEPTH));
    assign in_ready  = !w_full;
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (w_push && !w_pop)      count_d = count_q + CW'(1);
            else if (w_pop && !w_push) count_d = count_q - CW'(1);
            if (in_valid && w_full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; stale entries are hidden by the count gating.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= {in_ins, in_pcp4};
    end

    always_comb begin
        out_ins  = NOP;
        out_pcp4 = '0;
        if (out_valid) begin
            out_ins  = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
            out_pcp4 = mem_q[rd_ptr_q][WIDTH-1:0];
        end
    end

    assign count    = count_q;
    assign drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_yif_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_yif_queue
// Purpose  : Self-checking bench for yif_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yif_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_ins, in_pcp4, out_ins, out_pcp4;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq [$];
    int          drops = 0;

    always #5 clk = ~clk;

    yif_queue #(.DEPTH(DEPTH), .WIDTH(32), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pcp4(in_pcp4),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ins(out_ins), .out_pcp4(out_pcp4),
        .count(count), .drop_cnt(drop_cnt)
    );

    function automatic logic [63:0] exp_head();
        if (mq.size() == 0) return {NOP, 32'h0};
        return mq[0];
    endfunction

    // Drive one cycle of inputs, take the edge, advance the model, settle.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        bit full, empty;
        in_valid = v; in_ins = ins; in_pcp4 = pc; out_ready = rdy; flush = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if (v && full && drops < 255) drops++;
            if (rdy && !empty) void'(mq.pop_front());
            if (v && !full) mq.push_back({ins, pc});
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_ins = 0; in_pcp4 = 0; out_ready = 0; flush = 0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ins !== NOP || out_pcp4 !== 32'h0
            || count !== 3'd0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b ins=%h pc=%h count=%0d drop=%0d required 0 1 %h 0 0 0",
                     out_valid, in_ready, out_ins, out_pcp4, count, drop_cnt, NOP);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ins !== NOP || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b ready=%b ins=%h count=%0d required 0 1 %h 0",
                     out_valid, in_ready, out_ins, count, NOP);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] ins_t [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00302023};
        logic [31:0] pc_t  [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 4; i++) step(1'b1, ins_t[i], pc_t[i], 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d ready=%b required 4 0", count, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_ins !== ins_t[i] || out_pcp4 !== pc_t[i]) begin
                errors++;
                $display("FAIL drain_order[%0d]: valid=%b ins=%h pc=%h required 1 %h %h",
                         i, out_valid, out_ins, out_pcp4, ins_t[i], pc_t[i]);
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0 || out_ins !== NOP || out_pcp4 !== 32'h0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b ins=%h pc=%h required 0 %h 0",
                     out_valid, out_ins, out_pcp4, NOP);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp [$];
        int d0;
        d0 = drops;
        for (int i = 0; i < 4; i++) begin
            exp.push_back({$urandom(), 32'(i * 4 + 4)});
            step(1'b1, exp[i][63:32], exp[i][31:0], 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || drop_cnt !== 8'(d0 + 3)) begin
            errors++;
            $display("FAIL overflow: count=%0d drop=%0d required 4 %0d", count, drop_cnt, d0 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_ins, out_pcp4} !== exp[i]) begin
                errors++;
                $display("FAIL overflow_contents[%0d]: got %h required %h", i, {out_ins, out_pcp4}, exp[i]);
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] exp [$];
        for (int i = 0; i < 7; i++) exp.push_back({$urandom(), $urandom()});
        step(1'b1, exp[0][63:32], exp[0][31:0], 1'b0, 1'b0);
        step(1'b1, exp[1][63:32], exp[1][31:0], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, exp[i+2][63:32], exp[i+2][31:0], 1'b1, 1'b0);
            checks++;
            if (count !== 3'd2 || {out_ins, out_pcp4} !== exp[i+1]) begin
                errors++;
                $display("FAIL simul[%0d]: count=%0d head=%h required 2 %h", i, count, {out_ins, out_pcp4}, exp[i+1]);
            end
        end
    endtask

    task automatic test_flush();
        int d0;
        logic [31:0] ins;
        step(1'b1, 32'h11111113, 32'h100, 1'b0, 1'b0);
        d0 = int'(drop_cnt);
        step(1'b1, 32'h22222223, 32'h104, 1'b1, 1'b1);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_ins !== NOP || drop_cnt !== 8'(d0)) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b ins=%h drop=%0d required 0 0 %h %0d",
                     count, out_valid, out_ins, drop_cnt, NOP, d0);
        end
        step(1'b1, 32'h33333333, 32'h108, 1'b1, 1'b1);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_held: count=%0d valid=%b required 0 0", count, out_valid);
        end
        ins = $urandom();
        step(1'b1, ins, 32'h200, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_ins !== ins || out_pcp4 !== 32'h200 || count !== 3'd1) begin
            errors++;
            $display("FAIL flush_next_head: valid=%b ins=%h pc=%h count=%0d required 1 %h 200 1",
                     out_valid, out_ins, out_pcp4, count, ins);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        drops = 0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || drop_cnt !== 8'd0 || out_ins !== NOP) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d drop=%0d ins=%h required 0 0 0 %h",
                     out_valid, count, drop_cnt, out_ins, NOP);
        end
        #1 rst_n = 1'b1;
        step(1'b1, 32'hABCD0013, 32'h44, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd1 || out_ins !== 32'hABCD0013 || out_pcp4 !== 32'h44) begin
            errors++;
            $display("FAIL after_reset_push: count=%0d ins=%h pc=%h required 1 abcd0013 44",
                     count, out_ins, out_pcp4);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
        for (int i = 0; i < 262; i++) step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== 8'd255 || drops != 255) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d required 255", drop_cnt);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] h;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            h = exp_head();
            checks++;
            if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0)
                || in_ready !== (mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL random_flags[%0d]: count=%0d valid=%b ready=%b required count %0d",
                         i, count, out_valid, in_ready, mq.size());
            end
            checks++;
            if ({out_ins, out_pcp4} !== h || drop_cnt !== 8'(drops)) begin
                errors++;
                $display("FAIL random_data[%0d]: head=%h drop=%0d required %h %0d",
                         i, {out_ins, out_pcp4}, drop_cnt, h, drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_drop_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
